// File: rtl/stream_burst_arbiter.sv
// Round-robin burst arbiter: shares one upstream valid/ready stream between two
// consumers, holding each grant until the requested number of elements has moved.
module stream_burst_arbiter #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [N-1:0]  s_in,
  input  logic          s_in_valid,
  output logic          s_in_ready,
  input  logic          req0_valid,
  input  logic [CW-1:0] req0_count,
  output logic          req0_ready,
  output logic [N-1:0]  d0,
  output logic          d0_valid,
  input  logic          d0_ready,
  output logic          done0,
  input  logic          req1_valid,
  input  logic [CW-1:0] req1_count,
  output logic          req1_ready,
  output logic [N-1:0]  d1,
  output logic          d1_valid,
  input  logic          d1_ready,
  output logic          done1,
  output logic          busy,
  output logic          grant
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  logic          state;
  logic [CW-1:0] remaining;
  logic          grant_q;
  logic          last_q;
  logic          done0_q;
  logic          done1_q;

  logic          in_idle;
  logic          in_burst;
  logic          sel;
  logic [CW-1:0] sel_count;
  logic          accept;
  logic          xfer;

  assign in_idle  = (state == ST_IDLE);
  assign in_burst = (state == ST_BURST);

  // On a tie the consumer that did not own the previous burst wins.
  assign sel       = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign sel_count = sel ? req1_count : req0_count;

  // Gated by nrst so no handshake is offered while reset is held.
  assign accept     = in_idle & (req0_valid | req1_valid) & nrst;
  assign req0_ready = accept & ~sel;
  assign req1_ready = accept & sel;

  assign d0_valid   = in_burst & ~grant_q & s_in_valid;
  assign d1_valid   = in_burst &  grant_q & s_in_valid;
  assign d0         = (in_burst & ~grant_q) ? s_in : '0;
  assign d1         = (in_burst &  grant_q) ? s_in : '0;
  assign s_in_ready = in_burst & (grant_q ? d1_ready : d0_ready);
  assign xfer       = s_in_valid & s_in_ready;

  assign busy  = in_burst;
  assign grant = grant_q;
  assign done0 = done0_q;
  assign done1 = done1_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (sel_count != '0) begin
              state     <= ST_BURST;
              grant_q   <= sel;
              remaining <= sel_count;
            end else begin
              // Zero-length burst: acknowledge only, arbitration history untouched.
              done0_q <= ~sel;
              done1_q <= sel;
            end
          end
        end
        default: begin
          if (xfer) begin
            remaining <= remaining - 1'b1;
            if (remaining == CW'(1)) begin
              state   <= ST_IDLE;
              last_q  <= grant_q;
              done0_q <= ~grant_q;
              done1_q <= grant_q;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_burst_arbiter.sv
// Randomized scoreboard bench for stream_burst_arbiter: a transaction-level model
// predicts grant order and per-consumer data; a negedge monitor checks the DUT.
module tb_stream_burst_arbiter;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [N-1:0]  s_in = '0;
  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  logic          req0_valid = 1'b0;
  logic [CW-1:0] req0_count = '0;
  logic          req0_ready;
  logic [N-1:0]  d0;
  logic          d0_valid;
  logic          d0_ready = 1'b0;
  logic          done0;
  logic          req1_valid = 1'b0;
  logic [CW-1:0] req1_count = '0;
  logic          req1_ready;
  logic [N-1:0]  d1;
  logic          d1_valid;
  logic          d1_ready = 1'b0;
  logic          done1;
  logic          busy;
  logic          grant;

  stream_burst_arbiter #(.N(N), .CW(CW)) dut (
    .clk(clk), .nrst(nrst),
    .s_in(s_in), .s_in_valid(s_in_valid), .s_in_ready(s_in_ready),
    .req0_valid(req0_valid), .req0_count(req0_count), .req0_ready(req0_ready),
    .d0(d0), .d0_valid(d0_valid), .d0_ready(d0_ready), .done0(done0),
    .req1_valid(req1_valid), .req1_count(req1_count), .req1_ready(req1_ready),
    .d1(d1), .d1_valid(d1_valid), .d1_ready(d1_ready), .done1(done1),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  bit abort  = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    logic          k;
    logic [CW-1:0] c;
  } acc_t;

  acc_t         acc_q[$];
  logic [N-1:0] exp0_q[$];
  logic [N-1:0] exp1_q[$];
  logic         last_m = 1'b1;
  logic [N-1:0] base_m = 8'h10;

  function automatic void model_round(input bit r0, input logic [CW-1:0] c0,
                                      input bit r1, input logic [CW-1:0] c1);
    bit order[2];
    int n;
    n = 0;
    if (r0 && r1) begin
      order[0] = ~last_m; order[1] = last_m; n = 2;
    end else if (r0) begin
      order[0] = 1'b0; n = 1;
    end else if (r1) begin
      order[0] = 1'b1; n = 1;
    end
    for (int i = 0; i < n; i++) begin
      acc_t a;
      a.k = order[i];
      a.c = order[i] ? c1 : c0;
      acc_q.push_back(a);
      for (int j = 0; j < int'(a.c); j++) begin
        if (a.k) exp1_q.push_back(base_m);
        else     exp0_q.push_back(base_m);
        base_m++;
      end
      if (a.c != '0) last_m = a.k;
    end
  endfunction

  // ---------------- upstream source and consumer readiness ----------------
  logic [N-1:0] src_cnt = 8'h10;
  int           in_rate  = 100;
  int           rdy_rate = 100;
  bit           src_hs;

  initial forever begin
    @(negedge clk);
    src_hs = s_in_valid && s_in_ready;
    @(posedge clk);
    #1;
    if (src_hs) src_cnt++;
    s_in       = src_cnt;
    s_in_valid = ($urandom_range(99) < in_rate);
    d0_ready   = ($urandom_range(99) < rdy_rate);
    d1_ready   = ($urandom_range(99) < rdy_rate);
  end

  // ---------------- monitor / scoreboard ----------------
  int            cyc = 0;
  bit            mon_en = 1'b0;
  logic [CW-1:0] rem[2];
  bit            pend[2];
  int            due[2];
  acc_t          mon_a;
  logic [N-1:0]  mon_e;
  logic          mk, mv, mr, mdn;
  logic [N-1:0]  md;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en) begin
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        mk = req1_ready;
        check(!(req0_ready && req1_ready), "single_req_ready", 2, 1);
        if (acc_q.size() == 0) begin
          check(1'b0, "unexpected_accept", int'(mk), -1);
        end else begin
          mon_a = acc_q.pop_front();
          check(mon_a.k == mk, "accept_order", int'(mk), int'(mon_a.k));
          check(!busy, "idle_on_accept", int'(busy), 0);
          if (mon_a.c == '0) begin
            pend[mon_a.k] = 1'b1;
            due[mon_a.k]  = cyc + 1;
          end else begin
            rem[mon_a.k] = mon_a.c;
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        mv = k ? d1_valid : d0_valid;
        mr = k ? d1_ready : d0_ready;
        md = k ? d1 : d0;
        if (mv && mr) begin
          check(busy && (int'(grant) == k), "grant_on_xfer", int'(grant), k);
          if (rem[k] == '0 || (k ? exp1_q.size() : exp0_q.size()) == 0) begin
            check(1'b0, "extra_xfer", k, -1);
          end else begin
            mon_e = k ? exp1_q.pop_front() : exp0_q.pop_front();
            check(md == mon_e, k ? "d1_data" : "d0_data", int'(md), int'(mon_e));
            rem[k]--;
            if (rem[k] == '0) begin
              pend[k] = 1'b1;
              due[k]  = cyc + 1;
            end
          end
        end
      end
      check((s_in_valid && s_in_ready) == ((d0_valid && d0_ready) || (d1_valid && d1_ready)),
            "upstream_handshake", int'(s_in_ready), int'(d0_ready || d1_ready));
      for (int k = 0; k < 2; k++) begin
        mdn = k ? done1 : done0;
        if (mdn || (pend[k] && due[k] == cyc)) begin
          check(mdn && pend[k] && due[k] == cyc, k ? "done1_timing" : "done0_timing",
                int'(mdn), int'(pend[k]));
          pend[k] = 1'b0;
        end
      end
    end
  end

  // ---------------- request drivers ----------------
  task automatic serve(input int k);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (k == 1 ? req1_ready : req0_ready) break;
      n++;
      if (n > 500) begin
        check(1'b0, "accept_timeout", k, -1);
        abort = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (k == 1) req1_valid = 1'b0;
    else        req0_valid = 1'b0;
    if (abort) return;
    n = 0;
    forever begin
      @(negedge clk);
      if (k == 1 ? done1 : done0) break;
      n++;
      if (n > 500) begin
        check(1'b0, "done_timeout", k, -1);
        abort = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_round(input bit r0, input logic [CW-1:0] c0,
                           input bit r1, input logic [CW-1:0] c1);
    model_round(r0, c0, r1, c1);
    @(posedge clk);
    #1;
    req0_valid = r0; req0_count = c0;
    req1_valid = r1; req1_count = c1;
    fork
      if (r0) serve(0);
      if (r1) serve(1);
    join
  endtask

  function automatic logic [CW-1:0] rand_count();
    int p;
    p = $urandom_range(9);
    if (p == 0) return '0;
    if (p == 1) return 4'd15;
    return CW'($urandom_range(15, 1));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit r0, r1;

    req0_valid = 1'b1;
    #22;
    check({s_in_ready, d0_valid, d1_valid, req0_ready, req1_ready} == 5'b0,
          "reset_handshakes", int'({s_in_ready, d0_valid, d1_valid, req0_ready, req1_ready}), 0);
    check({busy, grant, done0, done1} == 4'b0, "reset_status",
          int'({busy, grant, done0, done1}), 0);
    req0_valid = 1'b0;
    @(negedge clk);
    nrst   = 1'b1;
    mon_en = 1'b1;

    run_round(1'b1, 4'd3, 1'b0, 4'd0);
    run_round(1'b1, 4'd2, 1'b1, 4'd2);
    run_round(1'b1, 4'd2, 1'b0, 4'd0);
    in_rate = 60; rdy_rate = 50;
    run_round(1'b0, 4'd0, 1'b1, 4'd4);
    run_round(1'b0, 4'd0, 1'b1, 4'd0);
    in_rate = 100; rdy_rate = 100;
    run_round(1'b1, 4'd15, 1'b0, 4'd0);
    run_round(1'b1, 4'd0, 1'b1, 4'd0);
    run_round(1'b1, 4'd5, 1'b1, 4'd0);

    for (int i = 0; i < 50 && !abort; i++) begin
      in_rate  = $urandom_range(100, 40);
      rdy_rate = $urandom_range(100, 40);
      r0 = $urandom_range(1);
      r1 = $urandom_range(1);
      if (!r0 && !r1) r0 = 1'b1;
      run_round(r0, rand_count(), r1, rand_count());
    end

    repeat (3) @(negedge clk);
    check(acc_q.size() == 0, "accepts_drained", acc_q.size(), 0);
    check(exp0_q.size() == 0, "d0_drained", exp0_q.size(), 0);
    check(exp1_q.size() == 0, "d1_drained", exp1_q.size(), 0);
    check(!pend[0] && !pend[1], "done_drained", int'({pend[1], pend[0]}), 0);
    mon_en = 1'b0;

    // Reset in the middle of a 5-element burst.
    in_rate = 100; rdy_rate = 100;
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_count = 4'd5;
    n = 0;
    while (!req0_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(req0_ready, "mid_reset_accept", int'(req0_ready), 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    n = 0;
    for (int t = 0; t < 100 && n < 2; t++) begin
      @(negedge clk);
      if (d0_valid && d0_ready) n++;
    end
    check(n == 2, "mid_reset_two_xfers", n, 2);
    #1;
    nrst = 1'b0;
    req1_valid = 1'b1; req1_count = 4'd1;
    #1;
    check({s_in_ready, d0_valid, d1_valid, req0_ready, req1_ready} == 5'b0,
          "mid_reset_handshakes", int'({s_in_ready, d0_valid, d1_valid, req0_ready, req1_ready}), 0);
    check({busy, grant, done0, done1} == 4'b0, "mid_reset_status",
          int'({busy, grant, done0, done1}), 0);
    check(d0 == '0, "mid_reset_d0", int'(d0), 0);
    repeat (3) begin
      @(negedge clk);
      check(!done0 && !done1, "mid_reset_no_done", int'({done1, done0}), 0);
    end
    @(posedge clk);
    #1;
    nrst = 1'b1;
    req0_valid = 1'b1; req0_count = 4'd1;
    @(negedge clk);
    check(req0_ready && !req1_ready, "post_reset_tie", int'({req1_ready, req0_ready}), 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stream_burst_arbiter.md
Name: stream_burst_arbiter

Overview:
- Shares one upstream stream source between two consumer ports.
- Each consumer requests a burst of K elements. The arbiter grants one consumer at a time, round-robin, and holds the grant until the whole burst has transferred.
- During a burst the granted consumer port is a zero-latency pass-through of the upstream valid/ready stream.
- Sits between a stream producer and multiple stream-consuming primitives (e.g. element-extraction stages) that would otherwise contend for the same source.

Parameters:
- N, 8, data width of stream elements.
- CW, 4, width of burst count; max burst is 2^CW-1.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- s_in  in  N  upstream stream data.
- s_in_valid  in  1  upstream element valid.
- s_in_ready  out  1  arbiter accepts upstream element.
- req0_valid  in  1  consumer 0 burst request.
- req0_count  in  CW  consumer 0 burst length.
- req0_ready  out  1  consumer 0 request accepted this cycle.
- d0  out  N  consumer 0 data.
- d0_valid  out  1  consumer 0 data valid.
- d0_ready  in  1  consumer 0 ready.
- done0  out  1  one-cycle pulse: consumer 0 burst complete.
- req1_valid, req1_count, req1_ready, d1, d1_valid, d1_ready, done1: same as port 0, for consumer 1.
- busy  out  1  burst in progress.
- grant  out  1  index of current/last granted consumer.

Behaviour:
- Reset (nrst low, async): state=IDLE, remaining=0, grant=0, busy=0, done0=done1=0, last=1 (consumer 0 wins the first tie). All valid/ready outputs are 0 while in reset.
- States: IDLE, BURST.
- IDLE, selection:
  - Candidates are requesters with reqK_valid=1.
  - If both are candidates, select the one not equal to last.
  - reqK_ready=1 (combinational) for the selected requester only.
  - s_in_ready=0 and d0_valid=d1_valid=0 in IDLE.
- IDLE, accepting reqK with count>0: next cycle state=BURST, grant=K, remaining=count, busy=1.
- IDLE, accepting reqK with count=0: acknowledged in the same cycle. doneK pulses next cycle. State stays IDLE; last and grant are unchanged.
- BURST with grant=K:
  - dK=s_in, dK_valid=s_in_valid, s_in_ready=dK_ready (combinational, zero latency).
  - Non-granted port: valid=0, data=0.
  - Both reqK_ready=0.
- Transfer condition: s_in_valid & dK_ready on the granted port. Each transfer decrements remaining.
- Last transfer (transfer with remaining==1): next cycle state=IDLE, busy=0, last=K, doneK=1 for exactly one cycle.
- Requests arriving during BURST wait; requesters hold reqK_valid and reqK_count stable until reqK_ready.
- Back-to-back bursts: a new grant can be accepted in the first IDLE cycle after a burst, so minimum one idle cycle between bursts. doneK and the next reqJ_ready can be high in the same cycle.
- Stall tolerance: a deasserted upstream valid or consumer ready freezes remaining indefinitely. No timeout.
- Mid-burst reset: burst is abandoned; all registers return to reset values; no done pulse.
- The arbiter never transfers more than the requested count, and never moves data with no grant.

Test Plan:
- Single burst: after reset, req0 count=3, s_in=0x10,0x11,0x12 continuously valid, d0_ready=1 -> req0_ready at T0; d0 carries 0x10..0x12 at T1..T3; done0 at T4; d1_valid always 0.
- Tie and round-robin: req0 and req1 both held with count=2 -> consumer 0 granted first; consumer 1 granted in the cycle done0 pulses; a third req0 is served after consumer 1.
- Backpressure: burst of 4 to consumer 1 with d1_ready low for 3 cycles mid-burst, and s_in_valid low for 2 cycles -> s_in_ready tracks d1_ready; exactly 4 elements in order, no duplicates; done1 one cycle after the 4th transfer.
- Zero count: req1 count=0 in IDLE -> req1_ready same cycle, done1 next cycle, busy stays 0, s_in_ready stays 0.
- Max count: req0 count=15 (CW=4) -> exactly 15 transfers, remaining reaches 0, state returns to IDLE.
- Reset mid-burst: nrst low after 2 of 5 transfers -> all outputs 0 immediately, no done pulse; after release a tie grants consumer 0.
